hist_readout: RTL

- Downstream consumer of the photon-counter histogram block.
- On a host read request, it snapshots either the 8-channel hit histogram or the 64-bin inter-photon-interval histogram.
- It then streams the snapshot as a framed byte sequence over a valid/ready byte interface to the UART/USB transmitter.
- It can optionally pulse the counter's histogram-reset input once the frame has fully drained.

---
 rtl/hist_pkg.sv | 30 +++
 rtl/hist_byte_mux.sv | 43 ++++
 rtl/hist_readout.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// hist_pkg -- shared definitions for the histogram readout block.
//
// Contents:
//   state_e          readout FSM states (IDLE, HDR, DATA, CSUM, DONE)
//   HDR_HIT_DEF      default header byte for a hit-histogram frame
//   HDR_IPI_DEF      default header byte for an interval-histogram frame
//   WORD_W_DEF       default bits per histogram bin
//   bytes_per_word() number of transmitted bytes per histogram bin
//
// CSUM is always part of the enum so the encoding is identical whether or
// not the checksum trailer (HIST_READOUT_CSUM_EN) is built.
package hist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_e;

  localparam logic [7:0] HDR_HIT_DEF = 8'hA5;
  localparam logic [7:0] HDR_IPI_DEF = 8'h5A;
  localparam int         WORD_W_DEF  = 32;

  function automatic int bytes_per_word(input int word_w);
    return word_w / 8;
  endfunction

endpackage

// File: rtl/hist_byte_mux.sv
// hist_byte_mux -- selects one byte out of the snapshot register file.
//
// Ports:
//   snap_flat  in  NW*WORD_W  snapshot words, word i at [i*WORD_W +: WORD_W]
//   word_sel   in  WIDX       word index (values >= NW yield 0)
//   byte_sel   in  BIDX       byte index inside the word, 0 = LSB byte
//   byte_o     out 8          selected byte
//
// Purely combinational; keeps the wide selection out of the FSM.
module hist_byte_mux #(
  parameter int NW     = 64,
  parameter int WORD_W = 32,
  parameter int WIDX   = 7,
  parameter int BIDX   = 2
) (
  input  logic [NW*WORD_W-1:0] snap_flat,
  input  logic [WIDX-1:0]      word_sel,
  input  logic [BIDX-1:0]      byte_sel,
  output logic [7:0]           byte_o
);

  localparam int BPW = WORD_W / 8;

  logic [7:0] byte_tab [NW][BPW];

  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    for (genvar gb = 0; gb < BPW; gb++) begin : g_byte
      assign byte_tab[gi][gb] = snap_flat[gi*WORD_W + gb*8 +: 8];
    end
  end

  always_comb begin
    byte_o = '0;
    for (int i = 0; i < NW; i++) begin
      for (int b = 0; b < BPW; b++) begin
        if (word_sel == WIDX'(i) && byte_sel == BIDX'(b)) begin
          byte_o = byte_tab[i][b];
        end
      end
    end
  end

endmodule

// File: rtl/hist_readout.sv
// hist_readout -- snapshots a histogram on host request and streams it as a
// framed, little-endian byte sequence over a valid/ready byte interface.
//
// Ports:
//   clkin          in   system clock (same domain as the photon counter)
//   rstn           in   asynchronous active-low reset
//   histo_flat     in   hit histogram, bin i at [i*WORD_W +: WORD_W]
//   ipihist_flat   in   interval histogram, same packing
//   rd_req         in   single-cycle read request (ignored while busy)
//   rd_sel         in   0 = hit histogram, 1 = interval histogram
//   rd_clr         in   1 = pulse resethist_out after the frame drains
//   busy           out  frame in progress
//   tx_data        out  byte to transmitter
//   tx_valid       out  tx_data valid
//   tx_ready       in   transmitter accepts byte
//   resethist_out  out  one-cycle pulse to the counter's histogram reset
//
// Build option: define HIST_READOUT_CSUM_EN to append one trailer byte equal
// to the XOR of the header and every data byte.
module hist_readout
  import hist_pkg::*;
#(
  parameter int         NHIST   = 8,
  parameter int         NIPI    = 64,
  parameter int         WORD_W  = WORD_W_DEF,
  parameter logic [7:0] HDR_HIT = HDR_HIT_DEF,
  parameter logic [7:0] HDR_IPI = HDR_IPI_DEF
) (
  input  logic                    clkin,
  input  logic                    rstn,
  input  logic [NHIST*WORD_W-1:0] histo_flat,
  input  logic [NIPI*WORD_W-1:0]  ipihist_flat,
  input  logic                    rd_req,
  input  logic                    rd_sel,
  input  logic                    rd_clr,
  output logic                    busy,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    resethist_out
);

  localparam int BPW  = bytes_per_word(WORD_W);
  localparam int NMAX = (NHIST > NIPI) ? NHIST : NIPI;
  // One spare code so the word index can step past the last word.
  localparam int WIDX = $clog2(NMAX + 1);
  localparam int BIDX = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BIDX-1:0] BYTE_LAST = BIDX'(BPW - 1);
  localparam logic [WIDX-1:0] LAST_HIT  = WIDX'(NHIST - 1);
  localparam logic [WIDX-1:0] LAST_IPI  = WIDX'(NIPI - 1);

  state_e            state_q;
  logic              busy_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic              resethist_q;
  logic              sel_q;
  logic              clr_q;
  logic [WIDX-1:0]   word_q, word_d;
  logic [BIDX-1:0]   byte_q, byte_d;
`ifdef HIST_READOUT_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic                   hs;
  logic                   load;
  logic                   last_byte;
  logic [WIDX-1:0]        last_word;
  logic [7:0]             mux_byte;
  logic [NMAX*WORD_W-1:0] snap_flat;

  assign hs        = tx_valid_q && tx_ready;
  assign load      = (state_q == ST_IDLE) && rd_req;
  assign last_word = sel_q ? LAST_IPI : LAST_HIT;
  assign last_byte = (state_q == ST_DATA) && (byte_q == BYTE_LAST) && (word_q == last_word);

  // Snapshot register file. Loaded on the accepting edge only, so later
  // changes on the histogram inputs never reach the frame. No reset: the
  // contents are always rewritten before they are read.
  for (genvar gi = 0; gi < NMAX; gi++) begin : g_snap
    logic [WORD_W-1:0] hit_word;
    logic [WORD_W-1:0] ipi_word;
    logic [WORD_W-1:0] snap_q;

    if (gi < NHIST) begin : g_hit
      assign hit_word = histo_flat[gi*WORD_W +: WORD_W];
    end else begin : g_hit_pad
      assign hit_word = '0;
    end

    if (gi < NIPI) begin : g_ipi
      assign ipi_word = ipihist_flat[gi*WORD_W +: WORD_W];
    end else begin : g_ipi_pad
      assign ipi_word = '0;
    end

    always_ff @(posedge clkin) begin
      if (load) begin
        snap_q <= rd_sel ? ipi_word : hit_word;
      end
    end

    assign snap_flat[gi*WORD_W +: WORD_W] = snap_q;
  end

  // Index of the byte to present after the current handshake. The mux looks
  // at the next index so tx_data can be a plain register.
  always_comb begin
    word_d = word_q;
    byte_d = byte_q;
    if (state_q == ST_HDR && hs) begin
      word_d = '0;
      byte_d = '0;
    end else if (state_q == ST_DATA && hs) begin
      if (byte_q == BYTE_LAST) begin
        byte_d = '0;
        word_d = word_q + WIDX'(1);
      end else begin
        byte_d = byte_q + BIDX'(1);
      end
    end
  end

  hist_byte_mux #(
    .NW     (NMAX),
    .WORD_W (WORD_W),
    .WIDX   (WIDX),
    .BIDX   (BIDX)
  ) u_byte_mux (
    .snap_flat (snap_flat),
    .word_sel  (word_d),
    .byte_sel  (byte_d),
    .byte_o    (mux_byte)
  );

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      resethist_q <= 1'b0;
      sel_q       <= 1'b0;
      clr_q       <= 1'b0;
      word_q      <= '0;
      byte_q      <= '0;
`ifdef HIST_READOUT_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      word_q <= word_d;
      byte_q <= byte_d;
      case (state_q)
        ST_IDLE: begin
          resethist_q <= 1'b0;
          if (rd_req) begin
            sel_q      <= rd_sel;
            clr_q      <= rd_clr;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= rd_sel ? HDR_IPI : HDR_HIT;
`ifdef HIST_READOUT_CSUM_EN
            csum_q     <= '0;
`endif
            state_q    <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (hs) begin
            tx_data_q <= mux_byte;
`ifdef HIST_READOUT_CSUM_EN
            csum_q    <= csum_q ^ tx_data_q;
`endif
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (hs) begin
`ifdef HIST_READOUT_CSUM_EN
            csum_q <= csum_q ^ tx_data_q;
`endif
            if (last_byte) begin
`ifdef HIST_READOUT_CSUM_EN
              // Trailer folds in the byte being accepted right now.
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= ST_CSUM;
`else
              tx_valid_q  <= 1'b0;
              resethist_q <= clr_q;
              state_q     <= ST_DONE;
`endif
            end else begin
              tx_data_q <= mux_byte;
            end
          end
        end

`ifdef HIST_READOUT_CSUM_EN
        ST_CSUM: begin
          if (hs) begin
            tx_valid_q  <= 1'b0;
            resethist_q <= clr_q;
            state_q     <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          resethist_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          busy_q      <= 1'b0;
          tx_valid_q  <= 1'b0;
          resethist_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign resethist_out = resethist_q;

endmodule
